// File: rtl/mem_arbiter.sv
// Two-master, one-slave round-robin arbiter for the picorv32-style native memory bus.
// One transaction in flight at a time; a watchdog aborts slave accesses that never complete.
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 256,
  parameter logic [31:0] ERR_RDATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic        m0_instr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m0_addr,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic        m1_instr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  input  logic        s_ready,
  output logic        s_instr,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_wdata,
  output logic [31:0] s_addr,
  input  logic [31:0] s_rdata,

  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        grant_nxt;
  logic [15:0] cnt;
  logic [15:0] cnt_nxt;
  logic        rd_load;
  logic        to_hit;
  logic [31:0] rd_value;

  // Slave request fields always follow the granted master; s_valid qualifies them.
  assign s_addr  = grant ? m1_addr  : m0_addr;
  assign s_wdata = grant ? m1_wdata : m0_wdata;
  assign s_wstrb = grant ? m1_wstrb : m0_wstrb;
  assign s_instr = grant ? m1_instr : m0_instr;

  assign rd_value = to_hit ? ERR_RDATA : s_rdata;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    cnt_nxt   = cnt;
    rd_load   = 1'b0;
    to_hit    = 1'b0;
    s_valid   = 1'b0;
    m0_ready  = 1'b0;
    m1_ready  = 1'b0;
    case (state)
      IDLE: begin
        // On contention the master that was not served last wins.
        if (m0_valid && m1_valid) begin
          grant_nxt = ~grant;
          cnt_nxt   = 16'd0;
          state_nxt = BUSY;
        end else if (m0_valid) begin
          grant_nxt = 1'b0;
          cnt_nxt   = 16'd0;
          state_nxt = BUSY;
        end else if (m1_valid) begin
          grant_nxt = 1'b1;
          cnt_nxt   = 16'd0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        s_valid = 1'b1;
        if (s_ready) begin
          rd_load   = 1'b1;
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          rd_load   = 1'b1;
          to_hit    = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      RESP: begin
        // The forced return to IDLE leaves the bus idle for one cycle,
        // which lets a registered slave ready fall before the next request.
        m0_ready  = ~grant;
        m1_ready  = grant;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      grant       <= 1'b1;
      cnt         <= 16'd0;
      timeout_err <= 1'b0;
      m0_rdata    <= 32'd0;
      m1_rdata    <= 32'd0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      cnt   <= cnt_nxt;
      if (to_hit) begin
        timeout_err <= 1'b1;
      end
      if (rd_load && !grant) begin
        m0_rdata <= rd_value;
      end
      if (rd_load && grant) begin
        m1_rdata <= rd_value;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-stepped slave model, per-master
// expected-read-data queues, and bus-trace records checked after each scenario.
module tb_mem_arbiter;

  localparam int TO = 16;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m0_ready, m0_instr;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_wdata, m0_addr, m0_rdata;
  logic        m1_valid, m1_ready, m1_instr;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_wdata, m1_addr, m1_rdata;
  logic        s_valid, s_ready, s_instr;
  logic [3:0]  s_wstrb;
  logic [31:0] s_wdata, s_addr, s_rdata;
  logic        grant, timeout_err;

  mem_arbiter #(.TIMEOUT(TO), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_instr(m0_instr), .m0_wstrb(m0_wstrb),
    .m0_wdata(m0_wdata), .m0_addr(m0_addr), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_instr(m1_instr), .m1_wstrb(m1_wstrb),
    .m1_wdata(m1_wdata), .m1_addr(m1_addr), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_instr(s_instr), .s_wstrb(s_wstrb),
    .s_wdata(s_wdata), .s_addr(s_addr), .s_rdata(s_rdata),
    .grant(grant), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave memory contents: one fixed word, everything else derived from the address.
  function automatic logic [31:0] slv_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'h12345678 : (a ^ 32'h5A5A_0000);
  endfunction

  assign s_rdata = slv_f(s_addr);

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] sv_addrs[$];
  int          sv_times[$];
  int          busy_lens[$];
  int          rep0, rep1;
  int          t_rdy0, t_rdy1, r1_cnt;
  logic        m0_rp, m1_rp, sv_prev;
  int          sv_run;
  logic [3:0]  last_wstrb;
  logic [31:0] last_wdata;
  logic        last_instr;
  int          slv_delay;
  bit          slv_hang;
  int          busy_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (m0_ready) begin
      check("m0_pulse_width", 32'(m0_rp), 32'd0);
      check("m0_ready_excl", 32'(m1_ready), 32'd0);
      if (q0.size() == 0) check("m0_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check("m0_rdata", m0_rdata, e);
      end
      t_rdy0 = cyc;
      if (rep0 > 0) begin
        rep0--;
        q0.push_back(slv_f(m0_addr));
      end else m0_valid = 1'b0;
    end
    if (m1_ready) begin
      check("m1_pulse_width", 32'(m1_rp), 32'd0);
      if (q1.size() == 0) check("m1_unexpected_ready", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check("m1_rdata", m1_rdata, e);
      end
      t_rdy1 = cyc;
      r1_cnt++;
      if (rep1 > 0) begin
        rep1--;
        q1.push_back(slv_f(m1_addr));
      end else m1_valid = 1'b0;
    end
    m0_rp = m0_ready;
    m1_rp = m1_ready;
    if (s_valid && !sv_prev) begin
      sv_addrs.push_back(s_addr);
      sv_times.push_back(cyc);
      last_wstrb = s_wstrb;
      last_wdata = s_wdata;
      last_instr = s_instr;
    end
    if (s_valid) sv_run++;
    else if (sv_run > 0) begin
      busy_lens.push_back(sv_run);
      sv_run = 0;
    end
    sv_prev = s_valid;
    if (s_valid) begin
      if (!slv_hang && busy_n == slv_delay) s_ready = 1'b1;
      busy_n++;
    end else begin
      s_ready = 1'b0;
      busy_n  = 0;
    end
  endtask

  task automatic issue(input bit m, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit ins, input int reps,
                       input logic [31:0] e);
    if (!m) begin
      m0_addr = a; m0_wdata = wd; m0_wstrb = ws; m0_instr = ins;
      m0_valid = 1'b1; rep0 = reps; q0.push_back(e);
    end else begin
      m1_addr = a; m1_wdata = wd; m1_wstrb = ws; m1_instr = ins;
      m1_valid = 1'b1; rep1 = reps; q1.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m0_valid || m1_valid) && n < maxc) begin
      step();
      n++;
    end
    check(tag, 32'(n < maxc), 32'd1);
    step();
    step();
  endtask

  task automatic clear_trace();
    sv_addrs.delete();
    sv_times.delete();
    busy_lens.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m0_valid = 1'b0; m1_valid = 1'b0; rep0 = 0; rep1 = 0;
    q0.delete(); q1.delete();
    step();
    step();
    resetn = 1'b1;
    step();
  endtask

  initial begin
    int n;
    int t_issue;
    resetn = 1'b0;
    m0_valid = 0; m0_instr = 0; m0_wstrb = 0; m0_wdata = 0; m0_addr = 0;
    m1_valid = 0; m1_instr = 0; m1_wstrb = 0; m1_wdata = 0; m1_addr = 0;
    s_ready = 0;
    rep0 = 0; rep1 = 0; r1_cnt = 0; t_rdy0 = 0; t_rdy1 = 0;
    m0_rp = 0; m1_rp = 0; sv_prev = 0; sv_run = 0; busy_n = 0;
    last_wstrb = 0; last_wdata = 0; last_instr = 0;
    slv_delay = 1; slv_hang = 0;

    // Reset state
    step();
    step();
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_m0_ready", 32'(m0_ready), 32'd0);
    check("rst_m1_ready", 32'(m1_ready), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);
    check("rst_m1_rdata", m1_rdata, 32'd0);
    check("rst_grant", 32'(grant), 32'd1);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    resetn = 1'b1;
    step();

    // Single m0 instruction read, slave ready one cycle after s_valid
    clear_trace();
    t_issue = cyc;
    issue(0, 32'h10, 32'h0, 4'h0, 1'b1, 0, 32'h12345678);
    wait_done("t1_wait", 20);
    check("t1_busy_len", 32'(busy_lens[0]), 32'd2);
    check("t1_sv_latency", 32'(sv_times[0] - t_issue), 32'd1);
    check("t1_ready_latency", 32'(t_rdy0 - t_issue), 32'd3);
    check("t1_instr", 32'(last_instr), 32'd1);
    check("t1_grant", 32'(grant), 32'd0);
    check("t1_m1_ready_cnt", 32'(r1_cnt), 32'd0);

    // Continuous contention from reset: strict alternation starting with m0
    do_reset();
    clear_trace();
    issue(0, 32'h100, 32'h0, 4'h0, 1'b0, 1, slv_f(32'h100));
    issue(1, 32'h200, 32'h0, 4'h0, 1'b0, 1, slv_f(32'h200));
    wait_done("t2_wait", 60);
    check("t2_count", 32'(sv_addrs.size()), 32'd4);
    check("t2_addr0", sv_addrs[0], 32'h100);
    check("t2_addr1", sv_addrs[1], 32'h200);
    check("t2_addr2", sv_addrs[2], 32'h100);
    check("t2_addr3", sv_addrs[3], 32'h200);
    check("t2_grant", 32'(grant), 32'd1);

    // m1 partial write passes fields straight through
    clear_trace();
    issue(1, 32'h44, 32'hCAFEF00D, 4'b0011, 1'b0, 0, slv_f(32'h44));
    wait_done("t3_wait", 20);
    check("t3_addr", sv_addrs[0], 32'h44);
    check("t3_wstrb", 32'(last_wstrb), 32'h3);
    check("t3_wdata", last_wdata, 32'hCAFEF00D);
    check("t3_instr", 32'(last_instr), 32'd0);

    // Slave never answers: watchdog abort, sticky error
    clear_trace();
    slv_hang = 1;
    issue(0, 32'h80, 32'h0, 4'h0, 1'b0, 0, 32'hDEADBEEF);
    wait_done("t4_wait", 60);
    check("t4_busy_len", 32'(busy_lens[0]), TO);
    check("t4_timeout_err", 32'(timeout_err), 32'd1);
    slv_hang = 0;
    issue(1, 32'h84, 32'h0, 4'h0, 1'b0, 0, slv_f(32'h84));
    wait_done("t4b_wait", 20);
    check("t4_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset during BUSY drops the transaction
    slv_delay = 5;
    issue(0, 32'h300, 32'h0, 4'h0, 1'b0, 0, slv_f(32'h300));
    n = 0;
    while (!s_valid && n < 20) begin
      step();
      n++;
    end
    check("t5_busy_reached", 32'(s_valid), 32'd1);
    step();
    resetn = 1'b0;
    #1;
    check("t5_async_s_valid", 32'(s_valid), 32'd0);
    check("t5_async_m0_ready", 32'(m0_ready), 32'd0);
    check("t5_async_m1_ready", 32'(m1_ready), 32'd0);
    check("t5_async_grant", 32'(grant), 32'd1);
    check("t5_async_timeout_err", 32'(timeout_err), 32'd0);
    check("t5_async_m1_rdata", m1_rdata, 32'd0);
    m0_valid = 1'b0; rep0 = 0; q0.delete();
    step();
    step();
    resetn = 1'b1;
    step();
    slv_delay = 1;
    issue(0, 32'h10, 32'h0, 4'h0, 1'b0, 0, 32'h12345678);
    wait_done("t5_fresh_wait", 20);

    // Late slave; m1 request arriving during m0 BUSY is served right after m0
    clear_trace();
    slv_delay = 10;
    issue(0, 32'h400, 32'h0, 4'h0, 1'b0, 0, slv_f(32'h400));
    n = 0;
    while (!s_valid && n < 20) begin
      step();
      n++;
    end
    step();
    issue(1, 32'h500, 32'h0, 4'h0, 1'b0, 0, slv_f(32'h500));
    wait_done("t6_wait", 80);
    check("t6_busy_len", 32'(busy_lens[0]), 32'd11);
    check("t6_addr0", sv_addrs[0], 32'h400);
    check("t6_addr1", sv_addrs[1], 32'h500);
    check("t6_m1_start", 32'(sv_times[1] - t_rdy0), 32'd2);
    check("t6_order", 32'(t_rdy1 > t_rdy0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

endmodule
